// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: default widths, per-stage field widths and the
// control-bit layout used to pack and unpack the control field.
package pipe_stage_reg_pkg;

  localparam int DEFAULT_DATA_W = 101;
  localparam int DEFAULT_CTRL_W = 9;
  localparam int DEFAULT_CNT_W  = 16;

  // Per-stage field widths for each register boundary
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 13;
  localparam int IDEX_DATA_W  = 138;
  localparam int EXMEM_CTRL_W = 9;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMTOREG   = 1;
  localparam int CTRL_MEMREAD_LO = 2;
  localparam int CTRL_MEMREAD_HI = 3;
  localparam int CTRL_MEMWRITE_LO = 4;
  localparam int CTRL_MEMWRITE_HI = 5;
  localparam int CTRL_JAL        = 6;
  localparam int CTRL_JUMP       = 7;
  localparam int CTRL_JR         = 8;

  typedef enum logic [1:0] {
    STAGE_IFID  = 2'd0,
    STAGE_IDEX  = 2'd1,
    STAGE_EXMEM = 2'd2,
    STAGE_MEMWB = 2'd3
  } stage_e;

  typedef struct packed {
    logic       jr;
    logic       jump;
    logic       jal;
    logic [1:0] mem_write;
    logic [1:0] mem_read;
    logic       mem_to_reg;
    logic       reg_write;
  } exmem_ctrl_t;

  function automatic int stage_ctrl_w(input stage_e stage);
    case (stage)
      STAGE_IFID:  return IFID_CTRL_W;
      STAGE_IDEX:  return IDEX_CTRL_W;
      STAGE_EXMEM: return EXMEM_CTRL_W;
      default:     return MEMWB_CTRL_W;
    endcase
  endfunction

  function automatic int stage_data_w(input stage_e stage);
    case (stage)
      STAGE_IFID:  return IFID_DATA_W;
      STAGE_IDEX:  return IDEX_DATA_W;
      STAGE_EXMEM: return EXMEM_DATA_W;
      default:     return MEMWB_DATA_W;
    endcase
  endfunction

  function automatic logic [EXMEM_CTRL_W-1:0] pack_exmem_ctrl(input exmem_ctrl_t c);
    logic [EXMEM_CTRL_W-1:0] v;
    v = '0;
    v[CTRL_REGWRITE]                      = c.reg_write;
    v[CTRL_MEMTOREG]                      = c.mem_to_reg;
    v[CTRL_MEMREAD_HI:CTRL_MEMREAD_LO]    = c.mem_read;
    v[CTRL_MEMWRITE_HI:CTRL_MEMWRITE_LO]  = c.mem_write;
    v[CTRL_JAL]                           = c.jal;
    v[CTRL_JUMP]                          = c.jump;
    v[CTRL_JR]                            = c.jr;
    return v;
  endfunction

  function automatic exmem_ctrl_t unpack_exmem_ctrl(input logic [EXMEM_CTRL_W-1:0] v);
    exmem_ctrl_t c;
    c.reg_write  = v[CTRL_REGWRITE];
    c.mem_to_reg = v[CTRL_MEMTOREG];
    c.mem_read   = v[CTRL_MEMREAD_HI:CTRL_MEMREAD_LO];
    c.mem_write  = v[CTRL_MEMWRITE_HI:CTRL_MEMWRITE_LO];
    c.jal        = v[CTRL_JAL];
    c.jump       = v[CTRL_JUMP];
    c.jr         = v[CTRL_JR];
    return c;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones
// instead of wrapping.
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and a saturating bubble counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready;
  assign emit   = m_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              s_valid;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      // Ready depends only on skid occupancy, so out_ready never reaches in_ready
      assign in_ready = !s_valid;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
          s_valid <= 1'b0;
          s_ctrl  <= '0;
          s_data  <= '0;
        end else if (Flush) begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
        end else if (!m_valid || emit) begin
          if (s_valid) begin
            m_valid <= 1'b1;
            m_ctrl  <= s_ctrl;
            m_data  <= s_data;
            s_valid <= accept;
            if (accept) begin
              s_ctrl <= in_ctrl;
              s_data <= in_data;
            end
          end else begin
            m_valid <= accept;
            if (accept) begin
              m_ctrl <= in_ctrl;
              m_data <= in_data;
            end
          end
        end else if (accept) begin
          s_valid <= 1'b1;
          s_ctrl  <= in_ctrl;
          s_data  <= in_data;
        end
      end
    end else begin : g_single
      assign in_ready = !m_valid | out_ready;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
        end else if (Flush) begin
          m_valid <= 1'b0;
        end else if (!m_valid || emit) begin
          m_valid <= accept;
          if (accept) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end
        end
      end
    end
  endgenerate

  // A bubble must never carry live control bits such as RegWrite or MemWrite
  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  pipe_sat_counter #(
    .WIDTH(CNT_W)
  ) u_bubble_cnt (
    .Clk  (Clk),
    .Clear(Reset),
    .inc  (!m_valid & out_ready),
    .count(bubble_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: a skid instance (4-bit counter) and a single-entry instance,
// each compared every cycle against a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 101;

  typedef logic [CTRL_W+DATA_W-1:0] beat_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Flush = 1'b0;

  logic              sk_in_valid = 1'b0;
  logic              sk_in_ready;
  logic [CTRL_W-1:0] sk_in_ctrl = '0;
  logic [DATA_W-1:0] sk_in_data = '0;
  logic              sk_out_valid;
  logic              sk_out_ready = 1'b1;
  logic [CTRL_W-1:0] sk_out_ctrl;
  logic [DATA_W-1:0] sk_out_data;
  logic [3:0]        sk_bubble_count;

  logic              ns_in_valid = 1'b0;
  logic              ns_in_ready;
  logic [CTRL_W-1:0] ns_in_ctrl = '0;
  logic [DATA_W-1:0] ns_in_data = '0;
  logic              ns_out_valid;
  logic              ns_out_ready = 1'b1;
  logic [CTRL_W-1:0] ns_out_ctrl;
  logic [DATA_W-1:0] ns_out_data;
  logic [15:0]       ns_bubble_count;

  int checks = 0;
  int failures = 0;

  beat_t      sk_q[$];
  beat_t      ns_q[$];
  logic [3:0] sk_bub = '0;
  logic [15:0] ns_bub = '0;
  bit         known = 1'b0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(4)) u_skid (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(sk_in_valid), .in_ready(sk_in_ready), .in_ctrl(sk_in_ctrl), .in_data(sk_in_data),
    .out_valid(sk_out_valid), .out_ready(sk_out_ready), .out_ctrl(sk_out_ctrl),
    .out_data(sk_out_data), .bubble_count(sk_bubble_count)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(16)) u_single (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_ctrl(ns_in_ctrl), .in_data(ns_in_data),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_ctrl(ns_out_ctrl),
    .out_data(ns_out_data), .bubble_count(ns_bubble_count)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // sel=1 drives the skid instance and idles the other; sel=0 the reverse
  task automatic applyStimulus(input bit sel, input logic rst, input logic fl, input logic v,
                               input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                               input logic ordy);
    @(posedge Clk);
    #1;
    Reset = rst;
    Flush = fl;
    if (sel) begin
      sk_in_valid = v; sk_in_ctrl = c; sk_in_data = d; sk_out_ready = ordy;
      ns_in_valid = 1'b0; ns_out_ready = 1'b1;
    end else begin
      ns_in_valid = v; ns_in_ctrl = c; ns_in_data = d; ns_out_ready = ordy;
      sk_in_valid = 1'b0; sk_out_ready = 1'b1;
    end
  endtask

  // Reference model: each instance is a FIFO of capacity 2 (skid) or 1 (single)
  always @(negedge Clk) begin : scoreboard
    logic sk_rdy;
    logic ns_rdy;
    sk_rdy = (sk_q.size() < 2);
    ns_rdy = (ns_q.size() == 0) || ns_out_ready;
    if (known) begin
      checkOutput("sk in_ready", 128'(sk_in_ready), 128'(sk_rdy));
      checkOutput("sk out_valid", 128'(sk_out_valid), 128'(sk_q.size() != 0));
      if (sk_q.size() != 0) begin
        checkOutput("sk out_ctrl", 128'(sk_out_ctrl), 128'(sk_q[0][DATA_W +: CTRL_W]));
        checkOutput("sk out_data", 128'(sk_out_data), 128'(sk_q[0][DATA_W-1:0]));
      end else begin
        checkOutput("sk bubble ctrl", 128'(sk_out_ctrl), 128'(0));
      end
      checkOutput("sk bubble_count", 128'(sk_bubble_count), 128'(sk_bub));
      checkOutput("ns in_ready", 128'(ns_in_ready), 128'(ns_rdy));
      checkOutput("ns out_valid", 128'(ns_out_valid), 128'(ns_q.size() != 0));
      if (ns_q.size() != 0) begin
        checkOutput("ns out_ctrl", 128'(ns_out_ctrl), 128'(ns_q[0][DATA_W +: CTRL_W]));
        checkOutput("ns out_data", 128'(ns_out_data), 128'(ns_q[0][DATA_W-1:0]));
      end else begin
        checkOutput("ns bubble ctrl", 128'(ns_out_ctrl), 128'(0));
      end
      checkOutput("ns bubble_count", 128'(ns_bubble_count), 128'(ns_bub));
    end
    if (Reset) begin
      sk_q.delete();
      ns_q.delete();
      sk_bub = '0;
      ns_bub = '0;
      known = 1'b1;
    end else if (known) begin
      if (sk_q.size() == 0 && sk_out_ready && sk_bub != 4'hF) sk_bub = sk_bub + 4'd1;
      if (ns_q.size() == 0 && ns_out_ready && ns_bub != 16'hFFFF) ns_bub = ns_bub + 16'd1;
      if (Flush) begin
        sk_q.delete();
        ns_q.delete();
      end else begin
        if (sk_q.size() != 0 && sk_out_ready) void'(sk_q.pop_front());
        if (sk_in_valid && sk_rdy) sk_q.push_back({sk_in_ctrl, sk_in_data});
        if (ns_q.size() != 0 && ns_out_ready) void'(ns_q.pop_front());
        if (ns_in_valid && ns_rdy) ns_q.push_back({ns_in_ctrl, ns_in_data});
      end
    end
  end

  initial begin
    // Reset for two edges, then one beat through an empty stage
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'h1FF, 101'h5, 1'b1);
    checkOutput("reset in_ready", 128'(sk_in_ready), 128'(1));
    checkOutput("reset out_valid", 128'(sk_out_valid), 128'(0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("first beat valid", 128'(sk_out_valid), 128'(1));
    checkOutput("first beat ctrl", 128'(sk_out_ctrl), 128'(9'h1FF));
    checkOutput("first beat data", 128'(sk_out_data), 128'(5));

    // Stall: beats 1 and 2 fill M and S, beat 3 waits upstream
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd1, 101'd1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd2, 101'd2, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd3, 101'd3, 1'b0);
    checkOutput("stall in_ready", 128'(sk_in_ready), 128'(0));
    checkOutput("stall head data", 128'(sk_out_data), 128'(1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd3, 101'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd3, 101'd3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Flush at occupancy 2 with beat 7 offered
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd8, 101'd8, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'd9, 101'd9, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 9'd7, 101'd7, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("flush out_valid", 128'(sk_out_valid), 128'(0));
    checkOutput("flush out_ctrl", 128'(sk_out_ctrl), 128'(0));
    checkOutput("flush in_ready", 128'(sk_in_ready), 128'(1));
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Reset and Flush together at occupancy 1
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 9'h11, 101'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 9'h12, 101'h12, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("rst+flush out_valid", 128'(sk_out_valid), 128'(0));
    checkOutput("rst+flush out_ctrl", 128'(sk_out_ctrl), 128'(0));
    checkOutput("rst+flush out_data", 128'(sk_out_data), 128'(0));
    checkOutput("rst+flush bubble", 128'(sk_bubble_count), 128'(0));
    checkOutput("rst+flush ns bubble", 128'(ns_bubble_count), 128'(0));

    // Idle long enough to saturate the 4-bit bubble counter
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("bubble saturated", 128'(sk_bubble_count), 128'(15));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("bubble holds", 128'(sk_bubble_count), 128'(15));

    // Single-entry instance with toggling out_ready and continuous valid
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, CTRL_W'(i + 1), DATA_W'(100 + i), (i % 2) == 0);
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Randomized traffic on both instances
    for (int i = 0; i < 600; i++) begin
      @(posedge Clk);
      #1;
      Reset = ($urandom_range(63) == 0);
      Flush = ($urandom_range(15) == 0);
      sk_in_valid  = 1'($urandom_range(1));
      sk_in_ctrl   = CTRL_W'($urandom);
      sk_in_data   = DATA_W'({$urandom, $urandom, $urandom, $urandom});
      sk_out_ready = ($urandom_range(3) != 0);
      ns_in_valid  = 1'($urandom_range(1));
      ns_in_ctrl   = CTRL_W'($urandom);
      ns_in_data   = DATA_W'({$urandom, $urandom, $urandom, $urandom});
      ns_out_ready = ($urandom_range(2) != 0);
    end
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
